// File: rtl/addr_decode_table_pkg.sv
// Shared constants, FSM encoding and match helper for the table-driven 68000 bus decoder.
package addr_decode_table_pkg;

  localparam logic [15:0] ADDR_DEC_DISABLED = 16'hFF00;

  typedef logic [1:0] dec_state_t;
  localparam dec_state_t IDLE   = 2'd0;
  localparam dec_state_t DECODE = 2'd1;
  localparam dec_state_t WAIT   = 2'd2;
  localparam dec_state_t ACK    = 2'd3;

  // Match word layout is {value[7:0], mask[7:0]}; a value bit outside the mask can never match.
  function automatic logic match_hit(input logic [7:0] addr_hi, input logic [15:0] match_word);
    return (addr_hi & match_word[7:0]) == match_word[15:8];
  endfunction

endpackage

// File: rtl/addr_decode_table_match.sv
// One chip-select channel: programmable match word and wait count, plus its address compare.
module addr_match_unit
  import addr_decode_table_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [15:0]       cfg_match,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic [7:0]        addr_hi,
  output logic              hit,
  output logic [WAIT_W-1:0] wait_cnt
);

  logic [15:0] match_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q  <= ADDR_DEC_DISABLED;
      wait_cnt <= '0;
    end else if (we) begin
      match_q  <= cfg_match;
      wait_cnt <= cfg_wait;
    end
  end

  assign hit = match_hit(addr_hi, match_q);

endmodule

// File: rtl/addr_decode_table.sv
// Registered table-driven chip-select decoder with wait states and unmapped/multi-hit flags.
// Optional fixed-window override ports are enabled by defining ADDR_DEC_SS_OVERRIDE_EN.
module addr_decode_table
  import addr_decode_table_pkg::*;
#(
  parameter int NUM_CS = 16,
  parameter int ADDR_W = 24,
  parameter int WAIT_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_as_n,
  input  logic [1:0]                cpu_ds_n,
  input  logic [ADDR_W-1:0]         cpu_word_addr,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CS)-1:0] cfg_idx,
  input  logic [15:0]               cfg_match,
  input  logic [WAIT_W-1:0]         cfg_wait,
`ifdef ADDR_DEC_SS_OVERRIDE_EN
  input  logic                      ss_override,
  output logic                      ss_reset_n,
  output logic                      ss_vec_n,
  output logic                      ss_save_n,
`endif
  output logic [NUM_CS-1:0]         cs_n,
  output logic                      dtack_n,
  output logic                      unmapped,
  output logic                      multi_hit
);

  localparam logic [NUM_CS-1:0] LSB_ONE = NUM_CS'(1);

  dec_state_t        state;
  logic [7:0]        addr_hi;
  logic [NUM_CS-1:0] hit_now;
  logic [WAIT_W-1:0] wait_arr [NUM_CS];
  logic [NUM_CS-1:0] win_onehot;
  logic [WAIT_W-1:0] win_wait;
  logic              access_start;
  logic              ss_hit;

  logic [NUM_CS-1:0] sel_q;
  logic [WAIT_W-1:0] wait_q;
  logic              unm_q;
  logic              multi_q;
  logic [WAIT_W-1:0] cnt;

  assign addr_hi      = cpu_word_addr[ADDR_W-1 -: 8];
  assign access_start = !cpu_as_n && !(&cpu_ds_n);

  // Only the top byte is decoded by the table; low bits feed the override windows when built in.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, cpu_word_addr[ADDR_W-9:0]};

  for (genvar g = 0; g < NUM_CS; g++) begin : g_ch
    addr_match_unit #(.WAIT_W(WAIT_W)) u_match (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (cfg_we && (int'(cfg_idx) == g)),
      .cfg_match(cfg_match),
      .cfg_wait (cfg_wait),
      .addr_hi  (addr_hi),
      .hit      (hit_now[g]),
      .wait_cnt (wait_arr[g])
    );
  end

  // Lowest index wins: isolate the least significant set bit and pick its wait count.
  assign win_onehot = hit_now & (~hit_now + LSB_ONE);

  always_comb begin
    win_wait = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (hit_now[i]) win_wait = wait_arr[i];
    end
  end

`ifdef ADDR_DEC_SS_OVERRIDE_EN
  logic [2:0] ss_now;
  logic [2:0] ss_q;

  assign ss_now[0] = ss_override && (cpu_word_addr[23:4] == 20'h0);
  assign ss_now[1] = ss_override && ((cpu_word_addr == 24'h00007c) || (cpu_word_addr == 24'h00007e));
  assign ss_now[2] = ss_override && (cpu_word_addr[23:8] == 16'hff00);
  assign ss_hit    = |ss_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_q                              <= '0;
      {ss_save_n, ss_vec_n, ss_reset_n} <= 3'b111;
    end else begin
      if (state == IDLE && access_start) ss_q <= ss_now;
      if (state == DECODE && !cpu_as_n) begin
        {ss_save_n, ss_vec_n, ss_reset_n} <= ~ss_q;
      end else if (cpu_as_n && (state == WAIT || state == ACK)) begin
        {ss_save_n, ss_vec_n, ss_reset_n} <= 3'b111;
      end
    end
  end
`else
  assign ss_hit = 1'b0;
`endif

  // Decode is captured at access start so table writes cannot disturb a cycle in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel_q     <= '0;
      wait_q    <= '0;
      unm_q     <= 1'b0;
      multi_q   <= 1'b0;
      cnt       <= '0;
      cs_n      <= '1;
      dtack_n   <= 1'b1;
      unmapped  <= 1'b0;
      multi_hit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access_start) begin
            sel_q   <= ss_hit ? '0 : win_onehot;
            wait_q  <= ss_hit ? '0 : win_wait;
            unm_q   <= !ss_hit && !(|hit_now);
            multi_q <= !ss_hit && (|(hit_now & (hit_now - LSB_ONE)));
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (cpu_as_n) begin
            state <= IDLE;
          end else begin
            cs_n      <= ~sel_q;
            cnt       <= wait_q;
            unmapped  <= unm_q;
            multi_hit <= multi_q;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cpu_as_n) begin
            cs_n      <= '1;
            unmapped  <= 1'b0;
            multi_hit <= 1'b0;
            state     <= IDLE;
          end else if (cnt == '0) begin
            dtack_n <= 1'b0;
            state   <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          if (cpu_as_n) begin
            cs_n      <= '1;
            dtack_n   <= 1'b1;
            unmapped  <= 1'b0;
            multi_hit <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_decode_table.sv
// Scoreboard bench for addr_decode_table: stimulus pushes reference-model expectations, a monitor
// pops them as each bus cycle completes. Override-window checks build when ADDR_DEC_SS_OVERRIDE_EN is defined.
module tb_addr_decode_table;

  localparam int NUM_CS = 16;
  localparam int ADDR_W = 24;
  localparam int WAIT_W = 4;
  localparam int IDX_W  = $clog2(NUM_CS);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cpu_as_n = 1'b1;
  logic [1:0]        cpu_ds_n = 2'b11;
  logic [ADDR_W-1:0] cpu_word_addr = '0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0;
  logic [15:0]       cfg_match = '0;
  logic [WAIT_W-1:0] cfg_wait = '0;
  logic [NUM_CS-1:0] cs_n;
  logic              dtack_n, unmapped, multi_hit;
`ifdef ADDR_DEC_SS_OVERRIDE_EN
  logic              ss_override = 1'b0;
  logic              ss_reset_n, ss_vec_n, ss_save_n;
`endif

  addr_decode_table #(.NUM_CS(NUM_CS), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_as_n     (cpu_as_n),
    .cpu_ds_n     (cpu_ds_n),
    .cpu_word_addr(cpu_word_addr),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_match    (cfg_match),
    .cfg_wait     (cfg_wait),
`ifdef ADDR_DEC_SS_OVERRIDE_EN
    .ss_override  (ss_override),
    .ss_reset_n   (ss_reset_n),
    .ss_vec_n     (ss_vec_n),
    .ss_save_n    (ss_save_n),
`endif
    .cs_n         (cs_n),
    .dtack_n      (dtack_n),
    .unmapped     (unmapped),
    .multi_hit    (multi_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NUM_CS-1:0] cs_n;
    bit                unm;
    bit                multi;
    logic [2:0]        ss_n;
    int                act_cyc;
    int                dtack_cyc;
    bit                abort;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] m_match [NUM_CS];
  int          m_wait  [NUM_CS];

  // Reference decode: list every matching entry, first in the list wins; cycle numbers follow
  // the bus contract (selects visible one edge after start, dtack two edges plus the wait count).
  function automatic exp_t model(input logic [23:0] addr, input bit ovr, input int start);
    exp_t e;
    int   hits[$];
    int   wt;
    logic [7:0] hi;
    hi = addr[23:16];
    e.cs_n = {NUM_CS{1'b1}};
    e.unm = 1'b0;
    e.multi = 1'b0;
    e.ss_n = 3'b111;
    e.abort = 1'b0;
    wt = 0;
    for (int i = 0; i < NUM_CS; i++)
      if ((hi & m_match[i][7:0]) == m_match[i][15:8]) hits.push_back(i);
    if (ovr && addr[23:4] == 20'h0) e.ss_n[0] = 1'b0;
    if (ovr && (addr == 24'h00007c || addr == 24'h00007e)) e.ss_n[1] = 1'b0;
    if (ovr && addr[23:8] == 16'hff00) e.ss_n[2] = 1'b0;
`ifndef ADDR_DEC_SS_OVERRIDE_EN
    e.ss_n = 3'b111;
`endif
    if (e.ss_n != 3'b111) wt = 0;
    else if (hits.size() == 0) e.unm = 1'b1;
    else begin
      e.cs_n[hits[0]] = 1'b0;
      e.multi = hits.size() > 1;
      wt = m_wait[hits[0]];
    end
    e.act_cyc = start + 1;
    e.dtack_cyc = start + 2 + wt;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic cfgWrite(input int idx, input logic [15:0] match, input int wt);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_idx = IDX_W'(idx);
    cfg_match = match;
    cfg_wait = WAIT_W'(wt);
    m_match[idx] = match;
    m_wait[idx] = wt;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One bus cycle; an optional table write lands on the same edge as the access start.
  task automatic applyStimulus(input logic [23:0] addr, input logic [1:0] ds, input bit ovr,
                               input bit abort_req, input bit do_wr, input int wr_idx,
                               input logic [15:0] wr_match, input int wr_wait);
    exp_t e;
    int   k;
    @(negedge clk);
    e = model(addr, ovr, cyc + 1);
    e.abort = abort_req;
    exp_q.push_back(e);
    cpu_word_addr = addr;
    cpu_ds_n = ds;
    cpu_as_n = 1'b0;
`ifdef ADDR_DEC_SS_OVERRIDE_EN
    ss_override = ovr;
`endif
    if (do_wr) begin
      cfg_we = 1'b1;
      cfg_idx = IDX_W'(wr_idx);
      cfg_match = wr_match;
      cfg_wait = WAIT_W'(wr_wait);
      m_match[wr_idx] = wr_match;
      m_wait[wr_idx] = wr_wait;
    end
    @(negedge clk);
    cfg_we = 1'b0;
    if (abort_req) begin
      @(negedge clk);
    end else begin
      k = 0;
      while (dtack_n && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (dtack_n) begin
        n_bad++;
        $display("[TB] FAIL dtack_timeout: dtack_n=%b after %0d cycles, required 0", dtack_n, k);
      end
    end
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
`ifdef ADDR_DEC_SS_OVERRIDE_EN
    ss_override = 1'b0;
`endif
  endtask

  // Monitor: a bus cycle begins when any select or flag shows and ends when all are released.
  initial begin : monitor
    bit                active;
    bit                dt_seen;
    bit                cur;
    int                act_c;
    int                dt_c;
    logic [NUM_CS-1:0] snap_cs;
    bit                snap_unm;
    bit                snap_multi;
    logic [2:0]        snap_ss;
    exp_t              e;
    active = 1'b0;
    dt_seen = 1'b0;
    act_c = 0;
    dt_c = 0;
    snap_ss = 3'b111;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 1'b0;
        continue;
      end
      cur = (cs_n != {NUM_CS{1'b1}}) || unmapped || multi_hit;
`ifdef ADDR_DEC_SS_OVERRIDE_EN
      cur = cur || !(ss_reset_n && ss_vec_n && ss_save_n);
`endif
      if (!active && !dtack_n) begin
        n_bad++;
        $display("[TB] FAIL stray_dtack: dtack_n=0 at cycle %0d, required 1 outside a decoded cycle", cyc);
      end
      if (!active && cur) begin
        active = 1'b1;
        dt_seen = 1'b0;
        act_c = cyc;
        snap_cs = cs_n;
        snap_unm = unmapped;
        snap_multi = multi_hit;
`ifdef ADDR_DEC_SS_OVERRIDE_EN
        snap_ss = {ss_save_n, ss_vec_n, ss_reset_n};
`endif
      end else if (active && cur && cs_n != snap_cs) begin
        n_bad++;
        $display("[TB] FAIL cs_n_unstable: got 0x%0h, required 0x%0h", cs_n, snap_cs);
      end
      if (active && !dt_seen && !dtack_n) begin
        dt_seen = 1'b1;
        dt_c = cyc;
      end
      if (active && !cur) begin
        active = 1'b0;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL unexpected_cycle: got access at cycle %0d, required none", act_c);
        end else begin
          e = exp_q.pop_front();
          checkOutput("cs_n", snap_cs, e.cs_n);
          checkOutput("unmapped", snap_unm, e.unm);
          checkOutput("multi_hit", snap_multi, e.multi);
          checkOutput("select_cycle", act_c, e.act_cyc);
`ifdef ADDR_DEC_SS_OVERRIDE_EN
          checkOutput("ss_n", snap_ss, e.ss_n);
`endif
          if (e.abort) checkOutput("abort_no_dtack", dt_seen, 1'b0);
          else checkOutput("dtack_cycle", dt_seen ? dt_c : -1, e.dtack_cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0]  vals  [5];
    logic [7:0]  masks [4];
    logic [7:0]  his   [8];
    logic [23:0] specials [4];
    logic [1:0]  dss   [3];
    logic [23:0] addr;
    bit          ovr;
    bit          ab;
    bit          wr;
    exp_t        p;
    vals = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    masks = '{8'hFF, 8'hF0, 8'hE0, 8'hC0};
    his = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00, 8'hFF, 8'h55};
    specials = '{24'h000003, 24'h00007c, 24'h00007e, 24'hff0012};
    dss = '{2'b00, 2'b01, 2'b10};
    for (int i = 0; i < NUM_CS; i++) begin
      m_match[i] = 16'hFF00;
      m_wait[i] = 0;
    end

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", cs_n, {NUM_CS{1'b1}});
    checkOutput("reset_dtack_n", dtack_n, 1'b1);
    checkOutput("reset_flags", {unmapped, multi_hit}, 2'b00);
    reset_n = 1'b1;

    applyStimulus(24'h100000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);
    cfgWrite(3, 16'h10FF, 2);
    applyStimulus(24'h100004, 2'b01, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);
    cfgWrite(2, 16'h20F0, 1);
    cfgWrite(5, 16'h20FF, 4);
    applyStimulus(24'h200000, 2'b10, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);
    cfgWrite(6, 16'h30FF, 15);
    applyStimulus(24'h300000, 2'b00, 1'b0, 1'b1, 1'b0, 0, 16'h0, 0);

    // Strobe low with both data strobes high is not an access.
    @(negedge clk);
    cpu_word_addr = 24'h100004;
    cpu_ds_n = 2'b11;
    cpu_as_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ds_high_no_start", {cs_n, unmapped, dtack_n}, {{NUM_CS{1'b1}}, 1'b0, 1'b1});
    cpu_as_n = 1'b1;

    applyStimulus(24'h100004, 2'b00, 1'b0, 1'b0, 1'b1, 3, 16'h40FF, 5);
    applyStimulus(24'h100004, 2'b00, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);
    applyStimulus(24'h400000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);

`ifdef ADDR_DEC_SS_OVERRIDE_EN
    cfgWrite(7, 16'h0000, 3);
    applyStimulus(24'h00007c, 2'b00, 1'b1, 1'b0, 1'b0, 0, 16'h0, 0);
    applyStimulus(24'hff0040, 2'b00, 1'b1, 1'b0, 1'b0, 0, 16'h0, 0);
    applyStimulus(24'h00007c, 2'b00, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);
`endif

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0)
        cfgWrite($urandom_range(0, NUM_CS - 1),
                 {vals[$urandom_range(0, 4)], masks[$urandom_range(0, 3)]}, $urandom_range(0, 7));
      addr = {his[$urandom_range(0, 7)], 16'($urandom)};
      if ($urandom_range(0, 3) == 0) addr = specials[$urandom_range(0, 3)];
`ifdef ADDR_DEC_SS_OVERRIDE_EN
      ovr = ($urandom_range(0, 1) == 1);
`else
      ovr = 1'b0;
`endif
      p = model(addr, ovr, 0);
      ab = (p.cs_n != {NUM_CS{1'b1}}) && (p.dtack_cyc - p.act_cyc >= 2) && ($urandom_range(0, 4) == 0);
      wr = ($urandom_range(0, 3) == 0);
      applyStimulus(addr, dss[$urandom_range(0, 2)], ovr, ab, wr, $urandom_range(0, NUM_CS - 1),
                    {vals[$urandom_range(0, 4)], masks[$urandom_range(0, 3)]}, $urandom_range(0, 7));
    end

    // Reset asserted in the middle of a long wait must release everything immediately.
    cfgWrite(0, 16'h30FF, 15);
    @(negedge clk);
    cpu_word_addr = 24'h300000;
    cpu_ds_n = 2'b00;
    cpu_as_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_cs0", cs_n[0], 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_cs_n", cs_n, {NUM_CS{1'b1}});
    checkOutput("async_reset_dtack_n", dtack_n, 1'b1);
    checkOutput("async_reset_flags", {unmapped, multi_hit}, 2'b00);
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < NUM_CS; i++) begin
      m_match[i] = 16'hFF00;
      m_wait[i] = 0;
    end
    applyStimulus(24'h300000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 16'h0, 0);

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
